// File: rtl/button_deb_multi_pkg.sv
// Shared constants and width helper for the multi-channel button debouncer.
package button_deb_multi_pkg;

  localparam int unsigned DEF_CLK_FREQ      = 95000;
  localparam int unsigned DEF_DEBOUNCE_MS   = 20;
  localparam int unsigned DEF_NB_BUTTONS    = 4;
  localparam int unsigned DEF_LONG_PRESS_MS = 1000;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_deb_chan.sv
// One button channel: synchroniser, debounce counter, hold counter and pulse outputs.
module button_deb_chan
  import button_deb_multi_pkg::*;
#(
  parameter int unsigned debounce_per_ms = DEF_DEBOUNCE_MS,
  parameter bit          active_low      = 1'b0,
  parameter int unsigned long_press_ms   = DEF_LONG_PRESS_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic button_in,
  output logic button_valid,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned DW = cnt_width(debounce_per_ms);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic          accept;

  assign accept = (sync2 != button_valid) && ms_tick &&
                  (deb_cnt == DW'(debounce_per_ms - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      deb_cnt       <= '0;
      button_valid  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync1         <= button_in ^ active_low;
      sync2         <= sync1;
      press_pulse   <= accept && !button_valid;
      release_pulse <= accept && button_valid;
      if (sync2 == button_valid)
        deb_cnt <= '0;
      else if (ms_tick)
        deb_cnt <= accept ? '0 : deb_cnt + 1'b1;
      if (accept)
        button_valid <= ~button_valid;
    end
  end

  generate
    if (long_press_ms == 0) begin : g_no_long
      assign long_press = 1'b0;
    end else begin : g_long
      localparam int unsigned HW = cnt_width(long_press_ms);

      logic [HW-1:0] hold_cnt;
      logic          hold_done;

      // Saturation at long_press_ms makes hold_done fire only once per press.
      assign hold_done = ms_tick && button_valid &&
                         (hold_cnt == HW'(long_press_ms - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_cnt   <= '0;
          long_press <= 1'b0;
        end else begin
          long_press <= hold_done && !accept;
          if (!button_valid)
            hold_cnt <= '0;
          else if (ms_tick && (hold_cnt != HW'(long_press_ms)))
            hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/button_deb_multi.sv
// Multi-channel button debouncer: one shared ms prescaler feeding nb_buttons channels.
module button_deb_multi
  import button_deb_multi_pkg::*;
#(
  parameter int unsigned clk_freq        = DEF_CLK_FREQ,
  parameter int unsigned debounce_per_ms = DEF_DEBOUNCE_MS,
  parameter int unsigned nb_buttons      = DEF_NB_BUTTONS,
  parameter bit          active_low      = 1'b0,
  parameter int unsigned long_press_ms   = DEF_LONG_PRESS_MS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [nb_buttons-1:0] button_in,
  output logic [nb_buttons-1:0] button_valid,
  output logic [nb_buttons-1:0] press_pulse,
  output logic [nb_buttons-1:0] release_pulse,
  output logic [nb_buttons-1:0] long_press
);

  localparam int unsigned PW = cnt_width(clk_freq - 1);

  logic [PW-1:0] presc;
  logic          ms_tick;

  assign ms_tick = (presc == PW'(clk_freq - 1));

  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (ms_tick)
      presc <= '0;
    else
      presc <= presc + 1'b1;
  end

  generate
    for (genvar i = 0; i < nb_buttons; i++) begin : g_chan
      button_deb_chan #(
        .debounce_per_ms(debounce_per_ms),
        .active_low     (active_low),
        .long_press_ms  (long_press_ms)
      ) u_chan (
        .clk          (clk),
        .rst          (rst),
        .ms_tick      (ms_tick),
        .button_in    (button_in[i]),
        .button_valid (button_valid[i]),
        .press_pulse  (press_pulse[i]),
        .release_pulse(release_pulse[i]),
        .long_press   (long_press[i])
      );
    end
  endgenerate

endmodule
